sobel_frame_ctrl: RTL

- Frame sequencer for the Sobel edge path. Generates pixel read addresses for the grayscale source and strobes the external 3x3 line-buffer/window shift.
- Asserts the window-valid enable (dl_sobel_en) into the Sobel convolution only when a complete 3x3 neighbourhood exists.
- Tracks the convolution's 2-cycle pipeline, drains it, and reports frame completion to the top-level controller.

---
 rtl/sobel_frame_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel edge path: walks the source image, strobes the
// 3x3 window shift, flags complete neighbourhoods and drains the conv pipeline.
module sobel_frame_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int ADDR_WD  = 19,
  parameter int PIPE_LAT = 2,
  localparam int CW      = $clog2(IMG_W),
  localparam int RW      = $clog2(IMG_H)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               pix_vld_i,
  output logic               pix_req_o,
  output logic [ADDR_WD-1:0] pix_addr_o,
  output logic               shift_en_o,
  output logic               dl_sobel_en,
  output logic               out_vld_o,
  output logic [CW-1:0]      col_o,
  output logic [RW-1:0]      row_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_WD-1:0]  addr_q, addr_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic [PIPE_LAT-1:0] dly_q, dly_d;
  logic                accept;
  logic                win_en;

  assign accept = (state_q == FETCH) && pix_vld_i;
  assign win_en = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      drain_q <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      drain_q <= drain_d;
      dly_q   <= dly_d;
    end
  end

  // Delay line runs free so out_vld_o stays aligned with the conv pipeline.
  always_comb begin
    dly_d    = dly_q;
    dly_d[0] = win_en;
    for (int i = 1; i < PIPE_LAT; i++) dly_d[i] = dly_q[i-1];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FETCH;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      FETCH: begin
        if (accept) begin
          if (row_q == ROW_LAST && col_q == COL_LAST) begin
            state_d = DRAIN;
            drain_d = DW'(PIPE_LAT);
            addr_d  = '0;
            col_d   = '0;
            row_d   = '0;
          end else begin
            addr_d = addr_q + ADDR_WD'(1);
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = DONE;
        else               drain_d = drain_q - DW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pix_req_o   = (state_q == FETCH);
  assign pix_addr_o  = addr_q;
  assign shift_en_o  = accept;
  assign dl_sobel_en = win_en;
  assign out_vld_o   = dly_q[PIPE_LAT-1];
  assign col_o       = col_q;
  assign row_o       = row_q;
  assign busy_o      = (state_q == FETCH) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE);

endmodule
